regfile_write_arbiter: RTL and testbench

Writer-side front end for the general-purpose register file's single write port. It merges writes from the in-order pipeline writeback stage with results from long-latency units (mul/div, cache-miss loads), buffering the latter in a small FIFO. It also keeps a per-register pending scoreboard so issue logic can stall on registers with outstanding long-latency results. It sits between the writeback stage / long-latency units and the register file, driving its write enable, write address and write data inputs.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_fifo.sv | 55 +++++
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and widths.
// Used by the write arbiter, its FIFO and the register file.
package regfile_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]     data;
   } wr_req_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO of register write requests.
// Holds long-latency results until the write port is free.
module regfile_wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  wr_req_t                  i_data,
   input  logic                     i_pop,
   output wr_req_t                  o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   wr_req_t        mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    cnt;
   logic           do_push;
   logic           do_pop;

   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end

   // Entry storage; contents are don't-care while empty.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_data;
   end

   assign o_head  = mem[rd_ptr];
   assign o_full  = (cnt == (AW+1)'(DEPTH));
   assign o_empty = (cnt == '0);
   assign o_level = cnt;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter with long-latency scoreboard.
// Optional REGFILE_WB_BYPASS_EN exposes the in-flight write to readers.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_pipe_valid,
   input  logic [REG_ADDR_WIDTH-1:0]     i_pipe_addr,
   input  logic [DATA_WIDTH-1:0]         i_pipe_data,
   input  logic                          i_lu_valid,
   input  logic [REG_ADDR_WIDTH-1:0]     i_lu_addr,
   input  logic [DATA_WIDTH-1:0]         i_lu_data,
   output logic                          o_lu_ready,
   input  logic                          i_issue_en,
   input  logic [REG_ADDR_WIDTH-1:0]     i_issue_addr,
   input  logic [REG_ADDR_WIDTH-1:0]     i_addr_ra,
   input  logic [REG_ADDR_WIDTH-1:0]     i_addr_rb,
   output logic                          o_busy_ra,
   output logic                          o_busy_rb,
   output logic                          o_w_en,
   output logic [REG_ADDR_WIDTH-1:0]     o_addr_w,
   output logic [DATA_WIDTH-1:0]         o_din,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
`ifdef REGFILE_WB_BYPASS_EN
   ,
   output logic                          o_byp_ra_hit,
   output logic                          o_byp_rb_hit,
   output logic [DATA_WIDTH-1:0]         o_byp_ra_data,
   output logic [DATA_WIDTH-1:0]         o_byp_rb_data
`endif
);

   wr_req_t               pipe_req;
   wr_req_t               lu_req;
   wr_req_t               head;
   wr_req_t               sel_req;
   logic                  sel_valid;
   logic                  pop;
   logic                  push;
   logic                  full;
   logic                  empty;
   logic [NUM_REGS-1:0]   pending;
   logic [NUM_REGS-1:0]   pending_nxt;

   assign pipe_req   = '{addr: i_pipe_addr, data: i_pipe_data};
   assign lu_req     = '{addr: i_lu_addr, data: i_lu_data};
   assign o_lu_ready = ~full & ~i_rst;
   assign push       = i_lu_valid & o_lu_ready;

   // Pipeline has priority; the FIFO drains only in idle slots.
   always_comb begin
      sel_req   = pipe_req;
      sel_valid = i_pipe_valid;
      pop       = 1'b0;
      if (!i_pipe_valid && !empty) begin
         sel_req   = head;
         sel_valid = 1'b1;
         pop       = 1'b1;
      end
   end

   regfile_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  (lu_req),
      .i_pop   (pop),
      .o_head  (head),
      .o_full  (full),
      .o_empty (empty),
      .o_level (o_fifo_level)
   );

   // Register the selected write; writes to x0 are suppressed.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_w_en   <= 1'b0;
         o_addr_w <= '0;
         o_din    <= '0;
      end else begin
         o_w_en <= sel_valid & (sel_req.addr != '0);
         if (sel_valid) begin
            o_addr_w <= sel_req.addr;
            o_din    <= sel_req.data;
         end
      end
   end

   // Pop clears, issue sets; set is applied last so it wins.
   always_comb begin
      pending_nxt = pending;
      if (pop)        pending_nxt[head.addr]    = 1'b0;
      if (i_issue_en) pending_nxt[i_issue_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) pending <= '0;
      else       pending <= pending_nxt;
   end

   assign o_busy_ra = (i_addr_ra != '0) & pending[i_addr_ra];
   assign o_busy_rb = (i_addr_rb != '0) & pending[i_addr_rb];

`ifdef REGFILE_WB_BYPASS_EN
   assign o_byp_ra_hit  = o_w_en & (o_addr_w == i_addr_ra) & (i_addr_ra != '0);
   assign o_byp_rb_hit  = o_w_en & (o_addr_w == i_addr_rb) & (i_addr_rb != '0);
   assign o_byp_ra_data = o_din;
   assign o_byp_rb_data = o_din;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised bench for regfile_write_arbiter.
// Reference model: queue of pending results plus a pending-bit array.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW = REG_ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic            i_pipe_valid = 1'b0;
   logic [AW-1:0]   i_pipe_addr = '0;
   logic [DW-1:0]   i_pipe_data = '0;
   logic            i_lu_valid = 1'b0;
   logic [AW-1:0]   i_lu_addr = '0;
   logic [DW-1:0]   i_lu_data = '0;
   logic            o_lu_ready;
   logic            i_issue_en = 1'b0;
   logic [AW-1:0]   i_issue_addr = '0;
   logic [AW-1:0]   i_addr_ra = '0;
   logic [AW-1:0]   i_addr_rb = '0;
   logic            o_busy_ra;
   logic            o_busy_rb;
   logic            o_w_en;
   logic [AW-1:0]   o_addr_w;
   logic [DW-1:0]   o_din;
   logic [$clog2(DEPTH):0] o_fifo_level;
`ifdef REGFILE_WB_BYPASS_EN
   logic            o_byp_ra_hit;
   logic            o_byp_rb_hit;
   logic [DW-1:0]   o_byp_ra_data;
   logic [DW-1:0]   o_byp_rb_data;
`endif

   regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pipe_valid (i_pipe_valid),
      .i_pipe_addr  (i_pipe_addr),
      .i_pipe_data  (i_pipe_data),
      .i_lu_valid   (i_lu_valid),
      .i_lu_addr    (i_lu_addr),
      .i_lu_data    (i_lu_data),
      .o_lu_ready   (o_lu_ready),
      .i_issue_en   (i_issue_en),
      .i_issue_addr (i_issue_addr),
      .i_addr_ra    (i_addr_ra),
      .i_addr_rb    (i_addr_rb),
      .o_busy_ra    (o_busy_ra),
      .o_busy_rb    (o_busy_rb),
      .o_w_en       (o_w_en),
      .o_addr_w     (o_addr_w),
      .o_din        (o_din),
      .o_fifo_level (o_fifo_level)
`ifdef REGFILE_WB_BYPASS_EN
      ,
      .o_byp_ra_hit  (o_byp_ra_hit),
      .o_byp_rb_hit  (o_byp_rb_hit),
      .o_byp_ra_data (o_byp_ra_data),
      .o_byp_rb_data (o_byp_rb_data)
`endif
   );

   always #5 i_clk = ~i_clk;

   int vectors = 0;
   int miscompares = 0;

   wr_req_t         mq[$];
   bit              mpend[NUM_REGS];
   bit              m_wen = 1'b0;
   logic [AW-1:0]   m_addr = '0;
   logic [DW-1:0]   m_din = '0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive, check against model, advance model.
   task automatic step(input bit pv, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input bit lv,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       output bit acc);
      wr_req_t e;
      @(negedge i_clk);
      i_pipe_valid = pv; i_pipe_addr = pa; i_pipe_data = pd;
      i_lu_valid = lv; i_lu_addr = la; i_lu_data = ld;
      i_issue_en = ie; i_issue_addr = ia;
      i_addr_ra = ra; i_addr_rb = rb;
      #1;
      check("w_en", 64'(o_w_en), 64'(m_wen));
      if (m_wen) begin
         check("addr_w", 64'(o_addr_w), 64'(m_addr));
         check("din", 64'(o_din), 64'(m_din));
      end
      check("level", 64'(o_fifo_level), 64'(mq.size()));
      check("lu_ready", 64'(o_lu_ready), 64'(mq.size() < DEPTH));
      check("busy_ra", 64'(o_busy_ra), 64'(ra != 0 && mpend[ra]));
      check("busy_rb", 64'(o_busy_rb), 64'(rb != 0 && mpend[rb]));
`ifdef REGFILE_WB_BYPASS_EN
      check("byp_ra_hit", 64'(o_byp_ra_hit), 64'(m_wen && m_addr == ra && ra != 0));
      check("byp_rb_hit", 64'(o_byp_rb_hit), 64'(m_wen && m_addr == rb && rb != 0));
      if (m_wen) check("byp_rb_data", 64'(o_byp_rb_data), 64'(m_din));
`endif
      acc = lv && (mq.size() < DEPTH);
      m_wen = 1'b0;
      if (pv) begin
         m_wen = (pa != 0); m_addr = pa; m_din = pd;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         m_wen = (e.addr != 0); m_addr = e.addr; m_din = e.data;
         mpend[e.addr] = 1'b0;
      end
      if (acc) mq.push_back('{addr: la, data: ld});
      if (ie && ia != 0) mpend[ia] = 1'b1;
   endtask

   task automatic idle(input int n, input logic [AW-1:0] ra);
      bit a;
      for (int i = 0; i < n; i++)
         step(0, 0, 0, 0, 0, 0, 0, 0, ra, 0, a);
   endtask

   // Asynchronous reset with immediate checks, then release.
   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      i_pipe_valid = 0; i_lu_valid = 0; i_issue_en = 0;
      i_addr_ra = 5'd9; i_addr_rb = 5'd7;
      #1;
      check("rst_w_en", 64'(o_w_en), 0);
      check("rst_addr", 64'(o_addr_w), 0);
      check("rst_din", 64'(o_din), 0);
      check("rst_level", 64'(o_fifo_level), 0);
      check("rst_ready", 64'(o_lu_ready), 0);
      check("rst_busy_ra", 64'(o_busy_ra), 0);
      check("rst_busy_rb", 64'(o_busy_rb), 0);
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      m_wen = 1'b0; m_addr = '0; m_din = '0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin
      bit a;
      bit lv = 0;
      bit hold = 0;
      logic [AW-1:0] la = '0;
      logic [DW-1:0] ld = '0;

      do_reset();

      // Pipeline only.
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, a);
      idle(2, 0);

      // Contention: LU waits behind four pipeline writes.
      step(1, 1, 32'hA0, 1, 7, 32'h11, 0, 0, 0, 0, a);
      for (int i = 1; i < 4; i++)
         step(1, AW'(i + 1), DW'(i), 0, 0, 0, 0, 0, 0, 0, a);
      idle(3, 0);

      // Full FIFO under continuous pipeline writes; LU held until taken.
      hold = 0;
      for (int i = 0; i < 8; i++) begin
         if (!hold) begin la = AW'(10 + i); ld = DW'(32'h100 + i); end
         step(1, 2, DW'(i), 1, la, ld, 0, 0, 0, 0, a);
         hold = !a;
      end
      for (int i = 0; i < 8; i++) begin
         if (!hold) begin la = AW'(20 + i); ld = DW'(32'h200 + i); end
         step(0, 0, 0, i < 2, la, ld, 0, 0, 0, 0, a);
         hold = hold ? !a : 1'b0;
      end
      idle(6, 0);

      // Scoreboard: issue, clear by pop, same-cycle set wins, x0.
      step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, a);
      idle(2, 9);
      step(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, a);
      idle(3, 9);
      step(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 0, a);
      step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, a);
      idle(2, 9);
      step(0, 0, 0, 1, 9, 32'h97, 0, 0, 9, 9, a);
      idle(2, 9);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, a);
      idle(1, 0);

      // LU result for x0 is popped but not written.
      step(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, a);
      idle(3, 0);

      // Bypass: write to 3 in flight seen on rb.
      step(1, 3, 32'h333, 0, 0, 0, 0, 0, 0, 3, a);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, a);

      // Three queued entries, then reset mid-stream.
      step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, a);
      step(1, 1, 1, 1, 4, 32'h44, 0, 0, 4, 0, a);
      step(1, 1, 2, 1, 5, 32'h45, 0, 0, 4, 0, a);
      step(1, 1, 3, 1, 6, 32'h46, 0, 0, 4, 0, a);
      step(1, 1, 4, 0, 0, 0, 0, 0, 4, 5, a);
      do_reset();
      idle(6, 4);

      // Randomised phases with varying pipeline density.
      hold = 0;
      for (int c = 0; c < 2000; c++) begin
         bit pv;
         int dens;
         dens = (c / 250) % 4;
         pv = ($urandom_range(0, 3) < dens);
         if (!hold) begin
            lv = ($urandom_range(0, 2) != 0);
            la = AW'($urandom_range(0, 7));
            ld = $urandom;
         end
         step(pv, AW'($urandom_range(0, 31)), $urandom, lv, la, ld,
              ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), a);
         hold = lv && !a;
         if (c == 1100) begin
            do_reset();
            hold = 0;
         end
      end
      idle(8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
